// File: rtl/dm_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : dm_arb_pkg                                                    |
// | Description: Shared encodings and default widths for the data-memory port  |
// |              arbiter (FSM states, access owner).                           |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package dm_arb_pkg;

  localparam int DEF_AW         = 8;
  localparam int DEF_DW         = 8;
  localparam int DEF_MEM_LAT    = 1;
  localparam int DEF_STARVE_LIM = 4;

  // Access sequencing: pick owner, strobe memory, wait for data, acknowledge
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Which requester owns the access currently in flight
  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_EXT = 1'b1
  } owner_t;

endpackage
`default_nettype wire

// File: rtl/dm_port_arbiter_lat_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : lat_timer                                                     |
// | Description: Loadable down-counter with zero flag. Counts the remaining    |
// |              memory latency while the arbiter sits in WAIT.                |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module lat_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Load takes priority; decrement stops at zero so the counter never wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule
`default_nettype wire

// File: rtl/dm_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : dm_port_arbiter                                               |
// | Description: Shares a single-port data memory between the CPU DM stage and |
// |              an external requester. One access at a time, CPU priority    |
// |              with bounded external starvation, CPU stalled until ack.     |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int STARVE_LIM = DEF_STARVE_LIM
) (
  input  logic          clk,
  input  logic          rst,
  // CPU DM stage
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_stall,
  // External requester (loader / DMA)
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic [DW-1:0] ext_rdata,
  output logic          ext_ack,
  // Memory macro
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int          LW         = $clog2(MEM_LAT + 1);
  localparam int          SW         = $clog2(STARVE_LIM + 1);
  localparam logic [LW-1:0] LAT_LOAD   = LW'(MEM_LAT - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

  state_t        state;
  owner_t        owner;
  logic          we_q;
  logic [SW-1:0] starve_cnt;
  logic          lat_zero;

  logic          grant_any;
  logic          grant_ext;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // Arbitration: CPU wins unless ext has waited through STARVE_LIM CPU grants
  always_comb begin
    grant_any = cpu_req | ext_req;
    grant_ext = ext_req & (~cpu_req | (starve_cnt == STARVE_MAX));
    sel_we    = grant_ext ? ext_we    : cpu_we;
    sel_addr  = grant_ext ? ext_addr  : cpu_addr;
    sel_wdata = grant_ext ? ext_wdata : cpu_wdata;
  end

  // The pipeline must freeze until its own access is acknowledged
  assign cpu_stall = cpu_req & ~cpu_ack;

  lat_timer #(
    .W (LW)
  ) u_lat_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (state == ISSUE),
    .load_val (LAT_LOAD),
    .dec      (state == WAIT),
    .zero     (lat_zero)
  );

  // Access sequencer with registered memory strobes, rdata capture and acks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_CPU;
      we_q       <= 1'b0;
      starve_cnt <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rdata  <= '0;
      ext_rdata  <= '0;
      cpu_ack    <= 1'b0;
      ext_ack    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Starvation only accumulates while ext is actually waiting
          if (!ext_req || grant_ext) begin
            starve_cnt <= '0;
          end else if (starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + SW'(1);
          end
          if (grant_any) begin
            owner     <= grant_ext ? OWN_EXT : OWN_CPU;
            we_q      <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_en    <= 1'b1;
            mem_we    <= sel_we;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          state  <= WAIT;
        end
        WAIT: begin
          if (lat_zero) begin
            // Stores leave the owner's read-data register untouched
            if (!we_q) begin
              if (owner == OWN_EXT) ext_rdata <= mem_rdata;
              else                  cpu_rdata <= mem_rdata;
            end
            if (owner == OWN_EXT) ext_ack <= 1'b1;
            else                  cpu_ack <= 1'b1;
            state <= RESP;
          end
        end
        RESP: begin
          cpu_ack <= 1'b0;
          ext_ack <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dm_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_dm_port_arbiter                                            |
// | Description: Directed self-checking bench for dm_port_arbiter. Instance a |
// |              uses MEM_LAT=1, instance b uses MEM_LAT=3.                    |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_dm_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance a (MEM_LAT=1)
  logic       a_cpu_req = 0, a_cpu_we = 0, a_ext_req = 0, a_ext_we = 0;
  logic [7:0] a_cpu_addr = 0, a_cpu_wdata = 0, a_ext_addr = 0, a_ext_wdata = 0;
  logic [7:0] a_cpu_rdata, a_ext_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic       a_cpu_ack, a_cpu_stall, a_ext_ack, a_mem_en, a_mem_we;

  // Instance b (MEM_LAT=3)
  logic       b_cpu_req = 0, b_cpu_we = 0, b_ext_req = 0, b_ext_we = 0;
  logic [7:0] b_cpu_addr = 0, b_cpu_wdata = 0, b_ext_addr = 0, b_ext_wdata = 0;
  logic [7:0] b_cpu_rdata, b_ext_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic       b_cpu_ack, b_cpu_stall, b_ext_ack, b_mem_en, b_mem_we;

  dm_port_arbiter #(.AW(8), .DW(8), .MEM_LAT(1), .STARVE_LIM(4)) dut_a (
    .clk(clk), .rst(rst),
    .cpu_req(a_cpu_req), .cpu_we(a_cpu_we), .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata),
    .cpu_rdata(a_cpu_rdata), .cpu_ack(a_cpu_ack), .cpu_stall(a_cpu_stall),
    .ext_req(a_ext_req), .ext_we(a_ext_we), .ext_addr(a_ext_addr), .ext_wdata(a_ext_wdata),
    .ext_rdata(a_ext_rdata), .ext_ack(a_ext_ack),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata)
  );

  dm_port_arbiter #(.AW(8), .DW(8), .MEM_LAT(3), .STARVE_LIM(4)) dut_b (
    .clk(clk), .rst(rst),
    .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_rdata(b_cpu_rdata), .cpu_ack(b_cpu_ack), .cpu_stall(b_cpu_stall),
    .ext_req(b_ext_req), .ext_we(b_ext_we), .ext_addr(b_ext_addr), .ext_wdata(b_ext_wdata),
    .ext_rdata(b_ext_rdata), .ext_ack(b_ext_ack),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata)
  );

  // Memory a: contents addr^C3 except 0x10=A5; data valid only MEM_LAT cycles after a read strobe
  logic [7:0] mem_a [256];
  logic [7:0] pipe_a;
  logic       pv_a;
  int         wcount_a = 0;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem_a[i] <= 8'(i) ^ 8'hC3;
      mem_a[8'h10] <= 8'hA5;
      pv_a         <= 1'b0;
    end else begin
      pv_a   <= a_mem_en && !a_mem_we;
      pipe_a <= mem_a[a_mem_addr];
      if (a_mem_en && a_mem_we) begin
        mem_a[a_mem_addr] <= a_mem_wdata;
        wcount_a          <= wcount_a + 1;
      end
    end
  end
  assign a_mem_rdata = pv_a ? pipe_a : 8'hEE;

  // Memory b: read-only, three-stage latency, garbage outside the valid cycle
  logic [7:0] pd_b0, pd_b1, pd_b2;
  logic [2:0] pv_b;
  always @(posedge clk) begin
    if (rst) begin
      pv_b <= 3'b000;
    end else begin
      pv_b  <= {pv_b[1:0], b_mem_en && !b_mem_we};
      pd_b0 <= (b_mem_addr == 8'h10) ? 8'hA5 : (b_mem_addr ^ 8'hC3);
      pd_b1 <= pd_b0;
      pd_b2 <= pd_b1;
    end
  end
  assign b_mem_rdata = pv_b[2] ? pd_b2 : 8'hEE;

  // Continuous invariants: never two acks together, never mem_we without mem_en
  int viol = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (a_cpu_ack && a_ext_ack) viol <= viol + 1;
      if (!a_mem_en && a_mem_we)  viol <= viol + 1;
      if (b_cpu_ack && b_ext_ack) viol <= viol + 1;
      if (!b_mem_en && b_mem_we)  viol <= viol + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [9:0] order;
  logic [9:0] exp_order;
  int         got;
  int         w0;

  initial begin
    tick();
    tick();
    rst = 1'b0;
    #1;
    // Reset state
    chk("rst mem_en",    a_mem_en,    0);
    chk("rst mem_we",    a_mem_we,    0);
    chk("rst mem_addr",  a_mem_addr,  0);
    chk("rst mem_wdata", a_mem_wdata, 0);
    chk("rst cpu_ack",   a_cpu_ack,   0);
    chk("rst ext_ack",   a_ext_ack,   0);
    chk("rst cpu_rdata", a_cpu_rdata, 0);
    chk("rst ext_rdata", a_ext_rdata, 0);

    // 1: lone CPU load of 0x10, MEM_LAT=1
    a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 8'h10;
    #1;
    chk("t1 stall t", a_cpu_stall, 1);
    chk("t1 mem_en t", a_mem_en, 0);
    tick();
    chk("t1 mem_en t+1", a_mem_en, 1);
    chk("t1 mem_we t+1", a_mem_we, 0);
    chk("t1 mem_addr t+1", a_mem_addr, 8'h10);
    chk("t1 stall t+1", a_cpu_stall, 1);
    tick();
    chk("t1 mem_en t+2", a_mem_en, 0);
    chk("t1 ack t+2", a_cpu_ack, 0);
    chk("t1 stall t+2", a_cpu_stall, 1);
    tick();
    chk("t1 ack t+3", a_cpu_ack, 1);
    chk("t1 rdata t+3", a_cpu_rdata, 8'hA5);
    chk("t1 stall t+3", a_cpu_stall, 0);
    tick();
    a_cpu_req = 0;
    chk("t1 ack t+4", a_cpu_ack, 0);
    chk("t1 rdata held", a_cpu_rdata, 8'hA5);

    // 2: ext store 0x3C to 0x20, then CPU load of 0x20
    w0 = wcount_a;
    a_ext_req = 1; a_ext_we = 1; a_ext_addr = 8'h20; a_ext_wdata = 8'h3C;
    tick();
    chk("t2 store mem_we", a_mem_we, 1);
    chk("t2 store mem_wdata", a_mem_wdata, 8'h3C);
    tick();
    tick();
    chk("t2 ext_ack", a_ext_ack, 1);
    chk("t2 cpu_ack quiet", a_cpu_ack, 0);
    chk("t2 ext_rdata unchanged by store", a_ext_rdata, 0);
    tick();
    a_ext_req = 0; a_ext_we = 0;
    a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 8'h20;
    tick();
    tick();
    tick();
    chk("t2 cpu_ack", a_cpu_ack, 1);
    chk("t2 cpu_rdata", a_cpu_rdata, 8'h3C);
    tick();
    a_cpu_req = 0;
    chk("t2 single write", wcount_a - w0, 1);

    // 3: both requesters held high, starvation bound of 4
    exp_order = 10'b10_0001_0000;
    order = '0;
    got = 0;
    a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 8'h10;
    a_ext_req = 1; a_ext_we = 0; a_ext_addr = 8'h30;
    for (int c = 0; c < 60 && got < 10; c++) begin
      tick();
      if (a_cpu_ack) begin
        order[got] = 1'b0;
        got++;
      end else if (a_ext_ack) begin
        order[got] = 1'b1;
        got++;
      end
    end
    a_cpu_req = 0; a_ext_req = 0;
    chk("t3 grants seen", got, 10);
    for (int i = 0; i < 10; i++) chk($sformatf("t3 grant %0d", i), order[i], exp_order[i]);
    chk("t3 ext_rdata", a_ext_rdata, 8'hF3);
    chk("t3 cpu_rdata", a_cpu_rdata, 8'hA5);
    tick();

    // 4: MEM_LAT=3 on instance b, ack exactly five cycles after request
    b_cpu_req = 1; b_cpu_we = 0; b_cpu_addr = 8'h10;
    tick();
    chk("t4 mem_en t+1", b_mem_en, 1);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("t4 ack t+%0d", i), b_cpu_ack, 0);
      tick();
    end
    chk("t4 ack t+5", b_cpu_ack, 1);
    chk("t4 rdata", b_cpu_rdata, 8'hA5);
    chk("t4 stall t+5", b_cpu_stall, 0);
    tick();
    b_cpu_req = 0;
    chk("t4 ack t+6", b_cpu_ack, 0);

    // 5: reset asserted while in WAIT
    a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 8'h10;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("t5 async mem_en", a_mem_en, 0);
    chk("t5 async mem_addr", a_mem_addr, 0);
    chk("t5 async cpu_rdata", a_cpu_rdata, 0);
    chk("t5 async ext_rdata", a_ext_rdata, 0);
    chk("t5 async cpu_ack", a_cpu_ack, 0);
    a_cpu_req = 0;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t5 no ack %0d", i), a_cpu_ack, 0);
      chk($sformatf("t5 no mem_en %0d", i), a_mem_en, 0);
    end
    a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 8'h11;
    tick();
    tick();
    tick();
    chk("t5 fresh ack", a_cpu_ack, 1);
    chk("t5 fresh rdata", a_cpu_rdata, 8'hD2);
    tick();
    a_cpu_req = 0;

    // 6: ext drops its request mid-access; CPU waits until after RESP
    a_ext_req = 1; a_ext_we = 0; a_ext_addr = 8'h30;
    tick();
    a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 8'h10;
    #1;
    chk("t6 stall t+1", a_cpu_stall, 1);
    tick();
    a_ext_req = 0;
    chk("t6 stall t+2", a_cpu_stall, 1);
    tick();
    chk("t6 ext_ack", a_ext_ack, 1);
    chk("t6 ext_rdata", a_ext_rdata, 8'hF3);
    chk("t6 cpu_ack t+3", a_cpu_ack, 0);
    chk("t6 stall t+3", a_cpu_stall, 1);
    tick();
    chk("t6 ext_ack t+4", a_ext_ack, 0);
    chk("t6 cpu_ack t+4", a_cpu_ack, 0);
    tick();
    chk("t6 cpu mem_en t+5", a_mem_en, 1);
    chk("t6 cpu mem_addr t+5", a_mem_addr, 8'h10);
    tick();
    chk("t6 cpu_ack t+6", a_cpu_ack, 0);
    tick();
    chk("t6 cpu_ack t+7", a_cpu_ack, 1);
    chk("t6 cpu_rdata", a_cpu_rdata, 8'hA5);
    tick();
    a_cpu_req = 0;
    tick();

    chk("invariants", viol, 0);
    chk("b ext idle", {b_ext_ack, b_ext_rdata, b_mem_wdata}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
